stage2_acs: RTL and testbench



---
 rtl/stage2_acs.sv | 131 +++++++++++++
 tb/tb_stage2_acs.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stage2_acs.sv
// stage2_acs: add-compare-select stage of a rate-1/2, K=3 (7,5) Viterbi decoder.
// Keeps four normalized path metrics (max-correlation), emits one survivor
// decision bit per state and the index of the best state every trellis step.
//
// Optional build macro: STAGE2_PM_OUT_EN adds pm0_out..pm3_out, which mirror
// the registered normalized metrics.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            d1_in..d4_in carry one trellis step this cycle
//   sof_in              start of frame (only when in_valid)
//   d1_in..d4_in        sign-magnitude branch metrics for codewords 00,11,10,01
//   dec_out[3:0]        survivor decision per new state (1 = odd predecessor)
//   best_state[1:0]     lowest state index whose normalized metric is 0
//   dec_valid           registered copy of in_valid
//   step_cnt[15:0]      trellis steps since the last start of frame
//   pm0_out..pm3_out    normalized metrics (STAGE2_PM_OUT_EN only)
module stage2_acs #(
    parameter int        PM_W    = 12,
    parameter int signed INIT_PM = -512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   sof_in,
    input  logic [7:0]             d1_in,
    input  logic [7:0]             d2_in,
    input  logic [7:0]             d3_in,
    input  logic [7:0]             d4_in,
    output logic [3:0]             dec_out,
    output logic [1:0]             best_state,
    output logic                   dec_valid,
    output logic [15:0]            step_cnt
`ifdef STAGE2_PM_OUT_EN
    ,
    output logic signed [PM_W-1:0] pm0_out,
    output logic signed [PM_W-1:0] pm1_out,
    output logic signed [PM_W-1:0] pm2_out,
    output logic signed [PM_W-1:0] pm3_out
`endif
);

    localparam logic signed [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    // Sign-magnitude to two's complement; 8'h80 naturally maps to 0.
    function automatic logic signed [PM_W-1:0] bm_conv(input logic [7:0] bm);
        logic signed [PM_W-1:0] mag;
        mag = {{(PM_W-7){1'b0}}, bm[6:0]};
        return bm[7] ? -mag : mag;
    endfunction

    logic signed [PM_W-1:0] pm_q   [4];
    logic signed [PM_W-1:0] old_pm [4];
    logic signed [PM_W-1:0] pe     [4];
    logic signed [PM_W-1:0] po     [4];
    logic signed [PM_W-1:0] new_pm [4];
    logic signed [PM_W-1:0] norm_pm[4];
    logic signed [PM_W-1:0] max_pm;
    logic signed [PM_W-1:0] b1, b2, b3, b4;
    logic [3:0]             dec_d;
    logic [1:0]             best_d;

    always_comb begin
        b1 = bm_conv(d1_in);
        b2 = bm_conv(d2_in);
        b3 = bm_conv(d3_in);
        b4 = bm_conv(d4_in);

        // Start of frame restarts from the known-zero-state metric set.
        for (int i = 0; i < 4; i++) begin
            if (sof_in) old_pm[i] = (i == 0) ? '0 : INIT_V;
            else        old_pm[i] = pm_q[i];
        end

        // Even predecessor {a,0}, odd predecessor {a,1} of new state {u,a}.
        pe[0] = old_pm[0] + b1;  po[0] = old_pm[1] + b2;
        pe[1] = old_pm[2] + b3;  po[1] = old_pm[3] + b4;
        pe[2] = old_pm[0] + b2;  po[2] = old_pm[1] + b1;
        pe[3] = old_pm[2] + b4;  po[3] = old_pm[3] + b3;

        // Odd predecessor must strictly win; ties go to the even one.
        for (int i = 0; i < 4; i++) begin
            dec_d[i]  = (po[i] > pe[i]);
            new_pm[i] = dec_d[i] ? po[i] : pe[i];
        end

        max_pm = new_pm[0];
        for (int i = 1; i < 4; i++) begin
            if (new_pm[i] > max_pm) max_pm = new_pm[i];
        end

        for (int i = 0; i < 4; i++) begin
            norm_pm[i] = new_pm[i] - max_pm;
        end

        // Scan downwards so the lowest zero-metric index is the one kept.
        best_d = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (norm_pm[i] == '0) best_d = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q[0]    <= '0;
            pm_q[1]    <= INIT_V;
            pm_q[2]    <= INIT_V;
            pm_q[3]    <= INIT_V;
            dec_out    <= '0;
            best_state <= '0;
            dec_valid  <= 1'b0;
            step_cnt   <= '0;
        end else begin
            dec_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) pm_q[i] <= norm_pm[i];
                dec_out    <= dec_d;
                best_state <= best_d;
                step_cnt   <= sof_in ? 16'd1 : step_cnt + 16'd1;
            end
        end
    end

`ifdef STAGE2_PM_OUT_EN
    assign pm0_out = pm_q[0];
    assign pm1_out = pm_q[1];
    assign pm2_out = pm_q[2];
    assign pm3_out = pm_q[3];
`endif

endmodule

// File: tb/tb_stage2_acs.sv
// Directed-vector bench for stage2_acs with hand-computed expected values.
module tb_stage2_acs;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sof_in;
    logic [7:0]  d1_in, d2_in, d3_in, d4_in;
    logic [3:0]  dec_out;
    logic [1:0]  best_state;
    logic        dec_valid;
    logic [15:0] step_cnt;
`ifdef STAGE2_PM_OUT_EN
    logic signed [11:0] pm0_out, pm1_out, pm2_out, pm3_out;
`endif

    int tests = 0;
    int fails = 0;

    stage2_acs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .sof_in     (sof_in),
        .d1_in      (d1_in),
        .d2_in      (d2_in),
        .d3_in      (d3_in),
        .d4_in      (d4_in),
        .dec_out    (dec_out),
        .best_state (best_state),
        .dec_valid  (dec_valid),
        .step_cnt   (step_cnt)
`ifdef STAGE2_PM_OUT_EN
        ,
        .pm0_out    (pm0_out),
        .pm1_out    (pm1_out),
        .pm2_out    (pm2_out),
        .pm3_out    (pm3_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] dec, input logic [1:0] best,
                           input logic [15:0] cnt, input logic vld);
        chk({tag, ".dec_out"},    {28'd0, dec_out},    {28'd0, dec});
        chk({tag, ".best_state"}, {30'd0, best_state}, {30'd0, best});
        chk({tag, ".step_cnt"},   {16'd0, step_cnt},   {16'd0, cnt});
        chk({tag, ".dec_valid"},  {31'd0, dec_valid},  {31'd0, vld});
    endtask

    task automatic chk_pm(input string tag, input int p0, input int p1, input int p2, input int p3);
`ifdef STAGE2_PM_OUT_EN
        chk({tag, ".pm0"}, 32'(pm0_out), p0);
        chk({tag, ".pm1"}, 32'(pm1_out), p1);
        chk({tag, ".pm2"}, 32'(pm2_out), p2);
        chk({tag, ".pm3"}, 32'(pm3_out), p3);
`else
        if (p0 + p1 + p2 + p3 > 0) $display("[TB] %s unexpected positive metric sum", tag);
`endif
    endtask

    // Drive one trellis step at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic sof, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        sof_in   = sof;
        d1_in = a; d2_in = b; d3_in = c; d4_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic sof);
        @(negedge clk);
        in_valid = 1'b0;
        sof_in   = sof;
        d1_in = 8'h55; d2_in = 8'hAA; d3_in = 8'h7F; d4_in = 8'hFF;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sof_in = 1'b0;
        d1_in = '0; d2_in = '0; d3_in = '0; d4_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 2'd0, 16'd0, 1'b0);
        chk_pm("reset", 0, -512, -512, -512);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 8'h90, 8'h10, 8'h00, 8'h00);
        chk_out("sof", 4'b0000, 2'd2, 16'd1, 1'b1);
        chk_pm("sof", -32, -528, 0, -528);

        step(1'b0, 8'h90, 8'h10, 8'h00, 8'h00);
        chk_out("step2", 4'b0000, 2'd1, 16'd2, 1'b1);
        chk_pm("step2", -48, 0, -16, 0);

        // Negative-zero BMs: every odd predecessor (metric 0) wins.
        step(1'b0, 8'h80, 8'h80, 8'h80, 8'h80);
        chk_out("negzero", 4'b1111, 2'd0, 16'd3, 1'b1);
        chk_pm("negzero", 0, 0, 0, 0);

        step(1'b0, 8'h05, 8'h83, 8'h7F, 8'hFF);
        chk_out("mixed1", 4'b1100, 2'd1, 16'd4, 1'b1);
        chk_pm("mixed1", -122, 0, -122, 0);

        step(1'b0, 8'h0A, 8'h00, 8'h8A, 8'h14);
        chk_out("mixed2", 4'b1111, 2'd1, 16'd5, 1'b1);
        chk_pm("mixed2", -20, 0, -10, -30);

        step(1'b0, 8'h00, 8'h00, 8'h81, 8'h32);
        chk_out("mixed3", 4'b0111, 2'd3, 16'd6, 1'b1);
        chk_pm("mixed3", -40, -20, -40, 0);

        // Hold, with sof_in asserted but unqualified.
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk_out("hold", 4'b0111, 2'd3, 16'd6, 1'b0);
        end
        chk_pm("hold", -40, -20, -40, 0);

        // Mid-stream asynchronous reset.
        step(1'b0, 8'h05, 8'h83, 8'h7F, 8'hFF);
        chk("prereset.dec_valid", {31'd0, dec_valid}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 16'd0, 1'b0);
        chk_pm("async_rst", 0, -512, -512, -512);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 8'h90, 8'h10, 8'h00, 8'h00);
        chk_out("post_rst", 4'b0000, 2'd2, 16'd1, 1'b1);
        chk_pm("post_rst", -32, -528, 0, -528);

        // Counter wrap: sof gives 1, 65534 more steps reach 16'hFFFF.
        step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 65534; i++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        end
        chk("wrap.ffff", {16'd0, step_cnt}, 32'h0000FFFF);
        chk("wrap.dec_valid", {31'd0, dec_valid}, 32'd1);
        step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("wrap.zero", {16'd0, step_cnt}, 32'd0);

        idle(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
